// File: rtl/dmem_controller.sv
// Data-memory controller for the MEM stage: word-organised RAM with byte/halfword/word
// access, sign/zero extension, configurable wait states and a pipeline freeze request.
module dmem_controller #(
   parameter int unsigned DEPTH       = 64,
   parameter int unsigned BASE_ADDR   = 1024,
   parameter int unsigned WAIT_STATES = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        memRead,
   input  logic        memWrite,
   input  logic [1:0]  memSize,
   input  logic        memSigned,
   input  logic [31:0] address,
   input  logic [31:0] data,
   output logic [31:0] memResult,
   output logic        ready,
   output logic        freeze,
   output logic        err
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        wr_q;
   logic [1:0]  size_q;
   logic        sgn_q;
   logic [31:0] addr_q;
   logic [31:0] data_q;
   logic [31:0] res_q;
   logic        ready_q;
   logic        err_q;
   logic [31:0] mem_q [DEPTH] = '{default: '0};

   logic          req;
   logic [31:0]   offs;
   logic [31:0]   index;
   logic [AW-1:0] widx;
   logic [1:0]    lane;
   logic          is_half;
   logic          is_word;
   logic          illegal;
   logic          do_access;

   // Pick the addressed byte/halfword/word out of a stored word and extend it to 32 bits.
   function automatic logic [31:0] extend_rd(input logic [31:0] word, input logic [1:0] ln,
                                             input logic [1:0] sz, input logic sgn);
      logic [31:0] w;
      logic [31:0] r;
      w = word >> {ln, 3'b000};
      case (sz)
         2'b00:   r = sgn ? {{24{w[7]}}, w[7:0]} : {24'b0, w[7:0]};
         2'b01:   r = sgn ? {{16{w[15]}}, w[15:0]} : {16'b0, w[15:0]};
         default: r = word;
      endcase
      return r;
   endfunction

   // Merge the active low bytes of the write data into the stored word at the given lane.
   function automatic logic [31:0] merge_wr(input logic [31:0] old, input logic [31:0] wdata,
                                            input logic [1:0] ln, input logic [1:0] sz);
      logic [3:0]  be;
      logic [31:0] wsh;
      logic [31:0] r;
      case (sz)
         2'b00:   be = 4'b0001 << ln;
         2'b01:   be = 4'b0011 << ln;
         default: be = 4'b1111;
      endcase
      wsh = wdata << {ln, 3'b000};
      for (int b = 0; b < 4; b++) begin
         r[b*8 +: 8] = be[b] ? wsh[b*8 +: 8] : old[b*8 +: 8];
      end
      return r;
   endfunction

   assign req       = memRead | memWrite;
   assign offs      = addr_q - 32'(BASE_ADDR);
   assign index     = offs >> 2;
   assign widx      = index[AW-1:0];
   assign lane      = addr_q[1:0];
   assign is_half   = (size_q == 2'b01);
   assign is_word   = size_q[1];
   assign illegal   = (addr_q < 32'(BASE_ADDR)) || (index >= 32'(DEPTH)) ||
                      (is_half && addr_q[0]) || (is_word && (lane != 2'b00));
   assign do_access = (state_q == ACCESS) && (cnt_q == 4'd0);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      freeze  = 1'b0;
      case (state_q)
         IDLE: begin
            if (req) begin
               freeze  = 1'b1;
               state_d = ACCESS;
               cnt_d   = 4'(WAIT_STATES);
            end
         end
         ACCESS: begin
            freeze = 1'b1;
            if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
            else               state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         res_q   <= 32'd0;
         ready_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ready_q <= do_access;
         err_q   <= do_access && illegal;
         if (do_access && !wr_q) begin
            res_q <= illegal ? 32'd0 : extend_rd(mem_q[widx], lane, size_q, sgn_q);
         end
      end
   end

   // Request latch: only loaded when a request is accepted out of IDLE.
   always_ff @(posedge clk) begin
      if (state_q == IDLE && req) begin
         wr_q   <= memWrite;
         size_q <= memSize;
         sgn_q  <= memSigned;
         addr_q <= address;
         data_q <= data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && do_access && wr_q && !illegal) begin
         mem_q[widx] <= merge_wr(mem_q[widx], data_q, lane, size_q);
      end
   end

   assign memResult = res_q;
   assign ready     = ready_q;
   assign err       = err_q;

endmodule

// File: tb/tb_dmem_controller.sv
// Scoreboard bench for dmem_controller: one instance with no wait states, one with three.
module tb_dmem_controller;

   logic        clk;
   logic        rst       [2];
   logic        memRead   [2];
   logic        memWrite  [2];
   logic [1:0]  memSize   [2];
   logic        memSigned [2];
   logic [31:0] address   [2];
   logic [31:0] data      [2];
   logic [31:0] memResult [2];
   logic        ready     [2];
   logic        freeze    [2];
   logic        err       [2];

   typedef struct {
      logic [31:0] res;
      logic        err;
   } exp_t;

   exp_t        sbq [$];
   logic [31:0] last_res [2];
   int          total = 0;
   int          bad   = 0;

   dmem_controller #(.DEPTH(64), .BASE_ADDR(1024), .WAIT_STATES(0)) u_dut0 (
      .clk(clk), .rst(rst[0]), .memRead(memRead[0]), .memWrite(memWrite[0]),
      .memSize(memSize[0]), .memSigned(memSigned[0]), .address(address[0]), .data(data[0]),
      .memResult(memResult[0]), .ready(ready[0]), .freeze(freeze[0]), .err(err[0]));

   dmem_controller #(.DEPTH(64), .BASE_ADDR(1024), .WAIT_STATES(3)) u_dut3 (
      .clk(clk), .rst(rst[1]), .memRead(memRead[1]), .memWrite(memWrite[1]),
      .memSize(memSize[1]), .memSigned(memSigned[1]), .address(address[1]), .data(data[1]),
      .memResult(memResult[1]), .ready(ready[1]), .freeze(freeze[1]), .err(err[1]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // One complete access; w selects the instance (0: no wait states, 1: three).
   task automatic access(input int w, input logic wr, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] exp_res, input logic exp_err, input string tag);
      exp_t e;
      int   nfrz;
      bit   seen;
      @(negedge clk);
      memWrite[w]  = wr;
      memRead[w]   = !wr;
      memSize[w]   = sz;
      memSigned[w] = sg;
      address[w]   = a;
      data[w]      = d;
      #1;
      chk({tag, "_frz_req"}, {31'b0, freeze[w]}, 32'd1);
      e.res = wr ? last_res[w] : exp_res;
      e.err = exp_err;
      if (!wr) last_res[w] = exp_res;
      sbq.push_back(e);
      nfrz = 0;
      seen = 1'b0;
      for (int n = 0; n < 40 && !seen; n++) begin
         @(negedge clk);
         if (ready[w]) seen = 1'b1;
         else if (freeze[w]) nfrz++;
      end
      chk({tag, "_ready"}, {31'b0, seen}, 32'd1);
      e = sbq.pop_front();
      if (seen) begin
         chk({tag, "_res"}, memResult[w], e.res);
         chk({tag, "_err"}, {31'b0, err[w]}, {31'b0, e.err});
         chk({tag, "_frz_cycles"}, 32'(nfrz), (w == 0) ? 32'd1 : 32'd4);
         chk({tag, "_frz_done"}, {31'b0, freeze[w]}, 32'd0);
      end
      memRead[w]  = 1'b0;
      memWrite[w] = 1'b0;
      @(negedge clk);
      chk({tag, "_ready_off"}, {31'b0, ready[w]}, 32'd0);
      chk({tag, "_err_off"}, {31'b0, err[w]}, 32'd0);
   endtask

   initial begin
      exp_t e;
      bit   seen;
      int   nwait;
      bit   any_ready;
      for (int w = 0; w < 2; w++) begin
         rst[w] = 1'b1; memRead[w] = 1'b0; memWrite[w] = 1'b0; memSize[w] = 2'b10;
         memSigned[w] = 1'b0; address[w] = 32'd0; data[w] = 32'd0; last_res[w] = 32'd0;
      end
      repeat (3) @(negedge clk);
      for (int w = 0; w < 2; w++) begin
         chk("rst_res", memResult[w], 32'd0);
         chk("rst_ready", {31'b0, ready[w]}, 32'd0);
         chk("rst_err", {31'b0, err[w]}, 32'd0);
         chk("rst_frz", {31'b0, freeze[w]}, 32'd0);
      end
      memRead[0] = 1'b1;
      #1;
      chk("rst_frz_req", {31'b0, freeze[0]}, 32'd1);
      memRead[0] = 1'b0;
      @(negedge clk);
      rst[0] = 1'b0;
      rst[1] = 1'b0;

      access(0, 1, 2'b10, 0, 32'd1028, 32'hDEADBEEF, 32'h0, 0, "w_word");
      access(0, 0, 2'b10, 0, 32'd1028, 32'h0, 32'hDEADBEEF, 0, "r_word");
      access(0, 1, 2'b10, 0, 32'd1032, 32'h11223344, 32'h0, 0, "w_1032");
      access(0, 1, 2'b00, 0, 32'd1033, 32'h000000AA, 32'h0, 0, "w_byte");
      access(0, 0, 2'b10, 0, 32'd1032, 32'h0, 32'h1122AA44, 0, "r_merge");
      access(0, 0, 2'b00, 1, 32'd1033, 32'h0, 32'hFFFFFFAA, 0, "r_sbyte");
      access(0, 0, 2'b00, 0, 32'd1033, 32'h0, 32'h000000AA, 0, "r_ubyte");
      access(0, 0, 2'b01, 1, 32'd1034, 32'h0, 32'h00001122, 0, "r_shalf_pos");
      access(0, 1, 2'b01, 0, 32'd1034, 32'h00008001, 32'h0, 0, "w_half");
      access(0, 0, 2'b01, 1, 32'd1034, 32'h0, 32'hFFFF8001, 0, "r_shalf_neg");
      access(0, 0, 2'b01, 0, 32'd1034, 32'h0, 32'h00008001, 0, "r_uhalf");
      access(0, 0, 2'b11, 0, 32'd1032, 32'h0, 32'h8001AA44, 0, "r_size11");
      access(0, 1, 2'b00, 0, 32'd1020, 32'h00000055, 32'h0, 1, "w_below");
      access(0, 0, 2'b10, 0, 32'd1024, 32'h0, 32'h00000000, 0, "r_word0");
      access(0, 0, 2'b10, 0, 32'd1280, 32'h0, 32'h00000000, 1, "r_above");
      access(0, 1, 2'b10, 0, 32'd1276, 32'hA5A5A5A5, 32'h0, 0, "w_last");
      access(0, 0, 2'b10, 0, 32'd1276, 32'h0, 32'hA5A5A5A5, 0, "r_last");
      access(0, 0, 2'b10, 0, 32'd1026, 32'h0, 32'h00000000, 1, "r_mis_word");
      access(0, 0, 2'b01, 0, 32'd1025, 32'h0, 32'h00000000, 1, "r_mis_half");
      access(0, 1, 2'b10, 0, 32'd1026, 32'hFFFFFFFF, 32'h0, 1, "w_mis_word");
      access(0, 1, 2'b01, 0, 32'd1029, 32'h0000FFFF, 32'h0, 1, "w_mis_half");
      access(0, 0, 2'b10, 0, 32'd1024, 32'h0, 32'h00000000, 0, "r_word0_again");
      access(0, 0, 2'b10, 0, 32'd1028, 32'h0, 32'hDEADBEEF, 0, "r_1028_again");

      access(1, 1, 2'b10, 0, 32'd1028, 32'hCAFEF00D, 32'h0, 0, "ws_w");
      access(1, 0, 2'b10, 0, 32'd1028, 32'h0, 32'hCAFEF00D, 0, "ws_r");

      // Request held high through DONE must not start a new access until IDLE.
      @(negedge clk);
      memRead[1] = 1'b1; memSize[1] = 2'b10; memSigned[1] = 1'b0; address[1] = 32'd1028;
      e.res = 32'hCAFEF00D; e.err = 1'b0;
      sbq.push_back(e);
      sbq.push_back(e);
      seen = 1'b0;
      for (int n = 0; n < 40 && !seen; n++) begin
         @(negedge clk);
         if (ready[1]) seen = 1'b1;
      end
      chk("hold_ready1", {31'b0, seen}, 32'd1);
      e = sbq.pop_front();
      chk("hold_res1", memResult[1], e.res);
      chk("hold_frz_done", {31'b0, freeze[1]}, 32'd0);
      @(negedge clk);
      chk("hold_idle_ready", {31'b0, ready[1]}, 32'd0);
      chk("hold_idle_frz", {31'b0, freeze[1]}, 32'd1);
      nwait = 0;
      seen  = 1'b0;
      for (int n = 1; n <= 40 && !seen; n++) begin
         @(negedge clk);
         if (ready[1]) begin
            seen  = 1'b1;
            nwait = n;
         end
      end
      chk("hold_ready2_lat", 32'(nwait), 32'd5);
      memRead[1] = 1'b0;
      e = sbq.pop_front();
      chk("hold_res2", memResult[1], e.res);
      chk("hold_err2", {31'b0, err[1]}, {31'b0, e.err});
      @(negedge clk);
      chk("hold_ready_off", {31'b0, ready[1]}, 32'd0);

      // Reset during the second ACCESS cycle of a write aborts it.
      @(negedge clk);
      memWrite[1] = 1'b1; memSize[1] = 2'b10; address[1] = 32'd1040; data[1] = 32'h12345678;
      @(negedge clk);
      @(negedge clk);
      rst[1] = 1'b1;
      memWrite[1] = 1'b0;
      @(negedge clk);
      rst[1] = 1'b0;
      chk("abort_frz", {31'b0, freeze[1]}, 32'd0);
      any_ready = 1'b0;
      for (int n = 0; n < 8; n++) begin
         @(negedge clk);
         if (ready[1] || freeze[1]) any_ready = 1'b1;
      end
      chk("abort_no_ready", {31'b0, any_ready}, 32'd0);
      chk("abort_res", memResult[1], 32'd0);
      last_res[1] = 32'd0;
      access(1, 0, 2'b10, 0, 32'd1040, 32'h0, 32'h00000000, 0, "abort_r1040");

      chk("sb_empty", 32'(sbq.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
